// File: rtl/up_packet_bus_if_if.sv
// ----------------------------------------------------------------------------
// up_packet_bus_if_if
// Bundles the host-uP pins and the register-bus request/reply signals used by
// up_packet_bus_if.
//   slave  : the bridge itself (receives uP pins and replies, drives the rest)
//   master : the environment (uP + register bus) facing the bridge
// Signals:
//   async_uP_start, async_uP_handshake_1, async_uP_RW : asynchronous uP pins
//   uP_data_in / uP_data_out / uP_data_oe             : byte bus pad split
//   uP_handshake_2, uP_ack                            : FPGA strobe, packet done
//   cmd_valid, cmd_command, cmd_reg_address, cmd_reg_data : register request
//   reply_valid, reply_data, reply_status             : register reply
// ----------------------------------------------------------------------------
interface up_packet_bus_if_if;
   logic        async_uP_start;
   logic        async_uP_handshake_1;
   logic        async_uP_RW;
   logic [7:0]  uP_data_in;
   logic [7:0]  uP_data_out;
   logic        uP_data_oe;
   logic        uP_handshake_2;
   logic        uP_ack;
   logic        cmd_valid;
   logic [7:0]  cmd_command;
   logic [7:0]  cmd_reg_address;
   logic [31:0] cmd_reg_data;
   logic        reply_valid;
   logic [31:0] reply_data;
   logic [31:0] reply_status;

   modport slave (
      input  async_uP_start, async_uP_handshake_1, async_uP_RW, uP_data_in,
      input  reply_valid, reply_data, reply_status,
      output uP_data_out, uP_data_oe, uP_handshake_2, uP_ack,
      output cmd_valid, cmd_command, cmd_reg_address, cmd_reg_data
   );

   modport master (
      output async_uP_start, async_uP_handshake_1, async_uP_RW, uP_data_in,
      output reply_valid, reply_data, reply_status,
      input  uP_data_out, uP_data_oe, uP_handshake_2, uP_ack,
      input  cmd_valid, cmd_command, cmd_reg_address, cmd_reg_data
   );
endinterface

// File: rtl/up_packet_bus_if.sv
// ----------------------------------------------------------------------------
// up_packet_bus_if
// Byte-wide asynchronous handshake slave between the host uP and the register
// bus. Receives a command packet (command, address, data LSB first), issues a
// single register request, waits for the reply, then returns data and status
// LSB first and raises uP_ack until the next packet start.
//
// Handshake protocol (both directions, four-phase):
//   RX byte: uP drives byte with RW=1 and raises handshake_1; bridge latches
//            the byte and raises handshake_2; uP drops handshake_1; bridge
//            drops handshake_2 and advances.
//   TX byte: bridge presents the byte (oe only while RW=0) and raises
//            handshake_2 one clock later; uP reads and raises handshake_1;
//            bridge drops handshake_2; uP drops handshake_1; bridge advances.
//   Register bus: cmd_valid is a single-cycle strobe with no back-pressure;
//            reply_valid is a single-cycle strobe honoured only in WAIT_REPLY.
//
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   bus           : up_packet_bus_if_if.slave (uP pins and register bus)
//   timeout_error : sticky abort flag, cleared by the next packet start
//   o_dbg_state   : current FSM state encoding
// ----------------------------------------------------------------------------
module up_packet_bus_if #(
   parameter int NOS_READ_BYTES  = 6,
   parameter int NOS_WRITE_BYTES = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                   clk,
   input  logic                   reset,
   up_packet_bus_if_if.slave      bus,
   output logic                   timeout_error,
   output logic [3:0]             o_dbg_state
);

   localparam int MAXB = (NOS_READ_BYTES > NOS_WRITE_BYTES) ? NOS_READ_BYTES : NOS_WRITE_BYTES;
   localparam int CW   = $clog2(MAXB + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE           = 4'd0,
      S_RX_WAIT_H1     = 4'd1,
      S_RX_WAIT_H1_LOW = 4'd2,
      S_EXEC           = 4'd3,
      S_WAIT_REPLY     = 4'd4,
      S_TX_PRESENT     = 4'd5,
      S_TX_WAIT_H1     = 4'd6,
      S_TX_WAIT_H1_LOW = 4'd7,
      S_DONE           = 4'd8
   } state_t;

   // synchronisers and start edge detect
   logic [SYNC_STAGES-1:0] r_sync_start;
   logic [SYNC_STAGES-1:0] r_sync_h1;
   logic [SYNC_STAGES-1:0] r_sync_rw;
   logic                   r_start_d;
   logic                   w_start;
   logic                   w_h1;
   logic                   w_rw;
   logic                   w_start_rise;

   // FSM and datapath registers
   state_t                           r_state;
   logic [CW-1:0]                    r_cnt;
   logic [NOS_READ_BYTES-1:0][7:0]   r_rx;
   logic [63:0]                      r_shift;
   logic                             r_hs2;
   logic                             r_ack;
   logic                             r_cmd_valid;
   logic                             r_tmo_err;
   logic [TW-1:0]                    r_tmo_cnt;

   state_t                           w_state_nxt;
   logic [CW-1:0]                    w_cnt_nxt;
   logic [NOS_READ_BYTES-1:0][7:0]   w_rx_nxt;
   logic [63:0]                      w_shift_nxt;
   logic                             w_hs2_nxt;
   logic                             w_ack_nxt;
   logic                             w_cmd_valid_nxt;
   logic                             w_tmo_err_nxt;
   logic                             w_abort;
   logic                             w_tmo_hit;
   logic                             w_tx_drive;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_start <= '0;
         r_sync_h1    <= '0;
         r_sync_rw    <= '0;
         r_start_d    <= 1'b0;
      end else begin
         r_sync_start <= {r_sync_start[SYNC_STAGES-2:0], bus.async_uP_start};
         r_sync_h1    <= {r_sync_h1[SYNC_STAGES-2:0], bus.async_uP_handshake_1};
         r_sync_rw    <= {r_sync_rw[SYNC_STAGES-2:0], bus.async_uP_RW};
         r_start_d    <= w_start;
      end
   end

   assign w_start      = r_sync_start[SYNC_STAGES-1];
   assign w_h1         = r_sync_h1[SYNC_STAGES-1];
   assign w_rw         = r_sync_rw[SYNC_STAGES-1];
   assign w_start_rise = w_start & ~r_start_d;

   // Stall counter: restarts on every state change, saturates otherwise.
   assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || (w_state_nxt != r_state)) begin
         r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_rx        <= '0;
         r_shift     <= '0;
         r_hs2       <= 1'b0;
         r_ack       <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_tmo_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rx        <= w_rx_nxt;
         r_shift     <= w_shift_nxt;
         r_hs2       <= w_hs2_nxt;
         r_ack       <= w_ack_nxt;
         r_cmd_valid <= w_cmd_valid_nxt;
         r_tmo_err   <= w_tmo_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rx_nxt        = r_rx;
      w_shift_nxt     = r_shift;
      w_hs2_nxt       = r_hs2;
      w_ack_nxt       = r_ack;
      w_cmd_valid_nxt = 1'b0;
      w_tmo_err_nxt   = r_tmo_err;
      w_abort         = 1'b0;

      case (r_state)
         S_IDLE, S_DONE: begin
            // Only these two states accept a new packet start.
            if (w_start_rise) begin
               w_state_nxt   = S_RX_WAIT_H1;
               w_cnt_nxt     = '0;
               w_ack_nxt     = 1'b0;
               w_tmo_err_nxt = 1'b0;
            end
         end
         S_RX_WAIT_H1: begin
            if (w_h1 && w_rw) begin
               for (int i = 0; i < NOS_READ_BYTES; i++) begin
                  if (r_cnt == CW'(i)) begin
                     w_rx_nxt[i] = bus.uP_data_in;
                  end
               end
               w_hs2_nxt   = 1'b1;
               w_state_nxt = S_RX_WAIT_H1_LOW;
            end else if (w_tmo_hit) begin
               w_abort = 1'b1;
            end
         end
         S_RX_WAIT_H1_LOW: begin
            if (!w_h1) begin
               w_hs2_nxt = 1'b0;
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == CW'(NOS_READ_BYTES - 1)) begin
                  w_state_nxt = S_EXEC;
               end else begin
                  w_state_nxt = S_RX_WAIT_H1;
               end
            end else if (w_tmo_hit) begin
               w_abort = 1'b1;
            end
         end
         S_EXEC: begin
            w_cmd_valid_nxt = 1'b1;
            w_state_nxt     = S_WAIT_REPLY;
         end
         S_WAIT_REPLY: begin
            if (bus.reply_valid) begin
               w_shift_nxt = {bus.reply_status, bus.reply_data};
               w_cnt_nxt   = '0;
               w_state_nxt = S_TX_PRESENT;
            end else if (w_tmo_hit) begin
               w_abort = 1'b1;
            end
         end
         S_TX_PRESENT: begin
            // Byte has been on the pad since entry; strobe one clock later.
            w_hs2_nxt   = 1'b1;
            w_state_nxt = S_TX_WAIT_H1;
         end
         S_TX_WAIT_H1: begin
            if (w_h1) begin
               w_hs2_nxt   = 1'b0;
               w_state_nxt = S_TX_WAIT_H1_LOW;
            end else if (w_tmo_hit) begin
               w_abort = 1'b1;
            end
         end
         S_TX_WAIT_H1_LOW: begin
            if (!w_h1) begin
               w_shift_nxt = {8'h00, r_shift[63:8]};
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == CW'(NOS_WRITE_BYTES - 1)) begin
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_TX_PRESENT;
               end
            end else if (w_tmo_hit) begin
               w_abort = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_abort) begin
         w_state_nxt     = S_IDLE;
         w_hs2_nxt       = 1'b0;
         w_ack_nxt       = 1'b0;
         w_cmd_valid_nxt = 1'b0;
         w_tmo_err_nxt   = 1'b1;
      end
   end

   assign w_tx_drive = (r_state == S_TX_PRESENT) || (r_state == S_TX_WAIT_H1) ||
                       (r_state == S_TX_WAIT_H1_LOW);

   // oe is gated by the synchronised RW so the pad never fights the uP.
   assign bus.uP_data_out     = w_tx_drive ? r_shift[7:0] : 8'h00;
   assign bus.uP_data_oe      = w_tx_drive & ~w_rw;
   assign bus.uP_handshake_2  = r_hs2;
   assign bus.uP_ack          = r_ack;
   assign bus.cmd_valid       = r_cmd_valid;
   assign bus.cmd_command     = r_rx[0];
   assign bus.cmd_reg_address = r_rx[1];
   assign bus.cmd_reg_data    = {r_rx[5], r_rx[4], r_rx[3], r_rx[2]};
   assign timeout_error       = r_tmo_err;
   assign o_dbg_state         = r_state;

endmodule
